// File: rtl/intersection_phase_scheduler_if.sv
// Intersection phase scheduler signal bundle.
//   jam_sensor_0..3 : per-road congestion flags (environment -> scheduler)
//   allow_0..3      : per-road green grants      (scheduler -> environment)
//   clear           : all-red clearance active
//   current_road    : last granted road (the granted road while green)
//   jam_mode        : current/last grant was jam-selected
// master = scheduler side, slave = road/controller side.
interface intersection_phase_scheduler_if;
    logic       jam_sensor_0;
    logic       jam_sensor_1;
    logic       jam_sensor_2;
    logic       jam_sensor_3;
    logic       allow_0;
    logic       allow_1;
    logic       allow_2;
    logic       allow_3;
    logic       clear;
    logic [1:0] current_road;
    logic       jam_mode;

    modport master (
        input  jam_sensor_0, jam_sensor_1, jam_sensor_2, jam_sensor_3,
        output allow_0, allow_1, allow_2, allow_3,
        output clear, current_road, jam_mode
    );

    modport slave (
        output jam_sensor_0, jam_sensor_1, jam_sensor_2, jam_sensor_3,
        input  allow_0, allow_1, allow_2, allow_3,
        input  clear, current_road, jam_mode
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Four-road intersection phase scheduler.
// Alternates an all-red CLEAR phase with a single-road GREEN phase. The road
// for the next green is chosen in the last CLEAR cycle: jammed roads are
// preferred (searched round-robin from current_road+1) until MAX_JAM_STREAK
// consecutive jam grants have been made, after which a normal round-robin
// grant is forced.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : intersection_phase_scheduler_if.master (sensors in, grants out)
module intersection_phase_scheduler #(
    parameter int GREEN_CYCLES     = 8,
    parameter int JAM_GREEN_CYCLES = 16,
    parameter int CLEAR_CYCLES     = 2,
    parameter int MAX_JAM_STREAK   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    intersection_phase_scheduler_if.master  bus
);
    localparam int NUM_ROADS = 4;

    // Terminal timer values; legal durations are 1..256 so each fits 8 bits.
    localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);
    localparam logic [7:0] GRN_LAST = 8'(GREEN_CYCLES - 1);
    localparam logic [7:0] JAM_LAST = 8'(JAM_GREEN_CYCLES - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_JAM_STREAK);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_GREEN = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [7:0]             timer, timer_nxt;
    logic [3:0]             streak, streak_nxt;
    logic [1:0]             cur_road, road_nxt;
    logic                   jam_q, jam_nxt;
    logic                   clear_q;
    logic [NUM_ROADS-1:0]   allow_q;

    logic [NUM_ROADS-1:0]   jam_vec;
    logic [1:0]             jam_pick;
    logic [1:0]             cand;
    logic [7:0]             grn_last;

    assign jam_vec = {bus.jam_sensor_3, bus.jam_sensor_2,
                      bus.jam_sensor_1, bus.jam_sensor_0};

    // First jammed road in order cur+1, cur+2, cur+3, cur. Walking the
    // offsets from far to near lets the nearest hit overwrite the others.
    // The 2-bit add wraps, so offset 4 lands on cur_road itself.
    always_comb begin
        cand     = '0;
        jam_pick = cur_road;
        for (int k = NUM_ROADS; k >= 1; k--) begin
            cand = cur_road + 2'(k);
            if (jam_vec[cand]) jam_pick = cand;
        end
    end

    assign grn_last = jam_q ? JAM_LAST : GRN_LAST;

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer + 8'd1;
        streak_nxt = streak;
        road_nxt   = cur_road;
        jam_nxt    = jam_q;
        unique case (state)
            ST_CLEAR: begin
                if (timer == CLR_LAST) begin
                    state_nxt = ST_GREEN;
                    timer_nxt = '0;
                    // Sensors only matter here, in the last clearance cycle.
                    if ((|jam_vec) && (streak < STREAK_MAX)) begin
                        road_nxt   = jam_pick;
                        jam_nxt    = 1'b1;
                        streak_nxt = streak + 4'd1;
                    end else begin
                        road_nxt   = cur_road + 2'd1;
                        jam_nxt    = 1'b0;
                        streak_nxt = '0;
                    end
                end
            end
            ST_GREEN: begin
                // Duration is fixed by jam_q latched at grant time, so
                // sensor activity during green cannot alter it.
                if (timer == grn_last) begin
                    state_nxt = ST_CLEAR;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            timer    <= '0;
            streak   <= '0;
            cur_road <= 2'd3;
            jam_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            streak   <= streak_nxt;
            cur_road <= road_nxt;
            jam_q    <= jam_nxt;
        end
    end

    // Grant outputs are loaded from the next-state decode so they change on
    // the same edge as the phase transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            clear_q <= 1'b1;
            allow_q <= '0;
        end else begin
            clear_q <= (state_nxt == ST_CLEAR);
            for (int i = 0; i < NUM_ROADS; i++) begin
                allow_q[i] <= (state_nxt == ST_GREEN) && (road_nxt == 2'(i));
            end
        end
    end

    assign bus.allow_0      = allow_q[0];
    assign bus.allow_1      = allow_q[1];
    assign bus.allow_2      = allow_q[2];
    assign bus.allow_3      = allow_q[3];
    assign bus.clear        = clear_q;
    assign bus.current_road = cur_road;
    assign bus.jam_mode     = jam_q;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenarios with literal
// expectations plus randomized sensor traffic checked every cycle against a
// phase-countdown reference model.
module tb_intersection_phase_scheduler;
    localparam int G  = 8;
    localparam int JG = 16;
    localparam int CL = 2;
    localparam int MX = 2;

    logic clk;
    logic rst;
    intersection_phase_scheduler_if bus ();

    intersection_phase_scheduler #(
        .GREEN_CYCLES(G), .JAM_GREEN_CYCLES(JG),
        .CLEAR_CYCLES(CL), .MAX_JAM_STREAK(MX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] allow_vec();
        return {bus.allow_3, bus.allow_2, bus.allow_1, bus.allow_0};
    endfunction

    // Packs {allow[3:0], clear, road[1:0], jam} for a single comparison.
    task automatic chk_out(input string nm, input logic [3:0] ea, input logic ec,
                           input logic [1:0] er, input logic ej);
        chk(nm, {24'd0, allow_vec(), bus.clear, bus.current_road, bus.jam_mode},
                {24'd0, ea, ec, er, ej});
    endtask

    task automatic set_jam(input logic [3:0] v);
        bus.jam_sensor_0 = v[0];
        bus.jam_sensor_1 = v[1];
        bus.jam_sensor_2 = v[2];
        bus.jam_sensor_3 = v[3];
    endtask

    // ---------------- reference model ----------------
    // Tracks which phase is showing and how many cycles of it remain.
    bit         m_valid   = 0;
    bit         m_clear   = 1;
    int         m_road    = 3;
    bit         m_jam     = 0;
    int         m_streak  = 0;
    int         m_left    = CL;
    bit         aborted   = 0;
    logic [3:0] sv;
    bit         found;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_clear = 1; m_road = 3; m_jam = 0;
            m_streak = 0; m_left = CL; aborted = 1;
        end else if (m_valid) begin
            if (m_left > 1) begin
                m_left--;
            end else if (m_clear) begin
                sv = {bus.jam_sensor_3, bus.jam_sensor_2, bus.jam_sensor_1, bus.jam_sensor_0};
                if (sv != 4'd0 && m_streak < MX) begin
                    found = 0;
                    for (int k = 1; k <= 4; k++) begin
                        if (!found && sv[(m_road + k) % 4]) begin
                            m_road = (m_road + k) % 4;
                            found = 1;
                        end
                    end
                    m_jam = 1;
                    m_streak++;
                end else begin
                    m_road = (m_road + 1) % 4;
                    m_jam = 0;
                    m_streak = 0;
                end
                m_clear = 0;
                m_left = m_jam ? JG : G;
            end else begin
                m_clear = 1;
                m_left = CL;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int glen = 0;
    bit gjam = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk_out("model", m_clear ? 4'b0000 : 4'(1 << m_road), m_clear,
                    2'(m_road), m_jam);
            chk("exclusive", 32'($countones({allow_vec(), bus.clear})), 32'd1);
            if (!bus.clear && allow_vec() != 4'd0) begin
                glen++;
                gjam = m_jam;
            end else begin
                if (glen > 0 && !aborted)
                    chk("green_len", 32'(glen), gjam ? 32'(JG) : 32'(G));
                glen = 0;
                aborted = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] jv;

    initial begin
        rst = 1'b1;
        set_jam(4'b0000);
        repeat (3) @(negedge clk);
        chk("rst_clear", 32'(bus.clear), 32'd1);
        chk("rst_allow", 32'(allow_vec()), 32'd0);
        chk("rst_road",  32'(bus.current_road), 32'd3);
        chk("rst_jam",   32'(bus.jam_mode), 32'd0);

        // No jams; a jam_0 pulse inside road 1's green must be ignored.
        rst = 1'b0;
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            case (c)
                2:  chk_out("a_g0_first", 4'b0001, 1'b0, 2'd0, 1'b0);
                9:  chk_out("a_g0_last",  4'b0001, 1'b0, 2'd0, 1'b0);
                10: chk_out("a_clr",      4'b0000, 1'b1, 2'd0, 1'b0);
                12: chk_out("a_g1_first", 4'b0010, 1'b0, 2'd1, 1'b0);
                19: chk_out("a_g1_last",  4'b0010, 1'b0, 2'd1, 1'b0);
                22: chk_out("a_g2_pulse", 4'b0100, 1'b0, 2'd2, 1'b0);
                32: chk_out("a_g3",       4'b1000, 1'b0, 2'd3, 1'b0);
                42: chk_out("a_wrap",     4'b0001, 1'b0, 2'd0, 1'b0);
                default: ;
            endcase
            if (c == 14) set_jam(4'b0001);
            if (c == 17) set_jam(4'b0000);
        end

        // jam_sensor_2 held high: two jam grants, forced road 3, jam again.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_jam(4'b0100);
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            case (c)
                2:  chk_out("b_j1_first", 4'b0100, 1'b0, 2'd2, 1'b1);
                17: chk_out("b_j1_last",  4'b0100, 1'b0, 2'd2, 1'b1);
                18: chk_out("b_clr",      4'b0000, 1'b1, 2'd2, 1'b1);
                20: chk_out("b_j2_first", 4'b0100, 1'b0, 2'd2, 1'b1);
                35: chk_out("b_j2_last",  4'b0100, 1'b0, 2'd2, 1'b1);
                38: chk_out("b_forced",   4'b1000, 1'b0, 2'd3, 1'b0);
                45: chk_out("b_forced_e", 4'b1000, 1'b0, 2'd3, 1'b0);
                46: chk_out("b_clr2",     4'b0000, 1'b1, 2'd3, 1'b0);
                48: chk_out("b_j3",       4'b0100, 1'b0, 2'd2, 1'b1);
                default: ;
            endcase
        end
        set_jam(4'b0000);

        // After road 1, jams on 1 and 3 in the last clear cycle -> road 3.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            case (c)
                12: chk_out("c_g1",       4'b0010, 1'b0, 2'd1, 1'b0);
                22: chk_out("c_j3_first", 4'b1000, 1'b0, 2'd3, 1'b1);
                37: chk_out("c_j3_last",  4'b1000, 1'b0, 2'd3, 1'b1);
                38: chk_out("c_clr",      4'b0000, 1'b1, 2'd3, 1'b1);
                default: ;
            endcase
            if (c == 21) set_jam(4'b1010);
            if (c == 22) set_jam(4'b0000);
        end

        // Reset in the 5th cycle of road 1's green.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) @(negedge clk);
        chk_out("d_g1_c5", 4'b0010, 1'b0, 2'd1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_out("d_abort", 4'b0000, 1'b1, 2'd3, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_out("d_clr2",  4'b0000, 1'b1, 2'd3, 1'b0);
        @(negedge clk);
        chk_out("d_g0",    4'b0001, 1'b0, 2'd0, 1'b0);

        // Random sensor traffic with rare resets.
        jv = 4'b0000;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 7) == 0)
                jv = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            set_jam(jv);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/intersection_phase_scheduler.md
INTERSECTION_PHASE_SCHEDULER -- requirements
Module: intersection_phase_scheduler

Interface
REQ-001 Parameter GREEN_CYCLES, default 8, normal green duration in clk cycles (legal 1..256).
REQ-002 Parameter JAM_GREEN_CYCLES, default 16, jam-selected green duration in clk cycles (legal 1..256).
REQ-003 Parameter CLEAR_CYCLES, default 2, all-red clearance duration between greens (legal 1..256).
REQ-004 Parameter MAX_JAM_STREAK, default 2, max consecutive jam-selected grants before a forced normal grant (legal 1..15).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 jam_sensor_0..jam_sensor_3  input  1 each  per-road congestion flag, synchronous to clk.
REQ-008 allow_0..allow_3  output  1 each  green grant per road, registered.
REQ-009 clear  output  1  all-red clearance phase active, registered.
REQ-010 current_road  output  2  index of the last granted road (the granted road while green), registered.
REQ-011 jam_mode  output  1  current or last grant was jam-selected, registered.

Function
REQ-012 The FSM SHALL have two states: CLEAR and GREEN; an internal 8-bit phase timer and 4-bit jam streak counter.
REQ-013 CLEAR: clear=1, all allow_x=0; timer counts 0..CLEAR_CYCLES-1; on timer==CLEAR_CYCLES-1 -> GREEN, timer=0.
REQ-014 Road selection SHALL be evaluated only in the last CLEAR cycle, sampling jam_sensor_x in that cycle; sensor activity at any other time is ignored.
REQ-015 If any sensor is set and streak<MAX_JAM_STREAK: grant the first jammed road searching current_road+1, +2, +3, then current_road itself (mod 4); jam_mode=1; streak+=1.
REQ-016 Otherwise (no sensor set, or streak==MAX_JAM_STREAK): grant current_road+1 mod 4 (3 wraps to 0); jam_mode=0; streak=0.
REQ-017 GREEN: exactly allow_<current_road>=1, clear=0; duration JAM_GREEN_CYCLES if jam_mode else GREEN_CYCLES; on timer==duration-1 -> CLEAR, timer=0.
REQ-018 Outputs SHALL update on the same edge as the state transition: first green cycle is the cycle after the last CLEAR cycle; no gap and no overlap.
REQ-019 At most one allow_x SHALL be high in any cycle; allow_x and clear SHALL never be high together; exactly one of {clear, any allow_x} is high every cycle.
REQ-020 current_road and jam_mode SHALL hold stable through GREEN and the following CLEAR, changing only at the CLEAR->GREEN edge.
REQ-021 Sensor changes during GREEN SHALL NOT shorten or extend the active green.

Reset
REQ-022 While rst=1 at a clk edge: state=CLEAR, timer=0, streak=0, current_road=3, jam_mode=0, clear=1, allow_0..3=0.
REQ-023 Reset asserted mid-GREEN or mid-CLEAR SHALL take effect at the next edge and abort the phase; after release a full CLEAR_CYCLES clearance precedes any green.
REQ-024 With current_road=3 after reset, the first normal grant SHALL be road 0.

Verification (defaults: GREEN=8, JAM_GREEN=16, CLEAR=2, MAX_JAM_STREAK=2)
REQ-025 No jams after reset release -> clear 2 cycles, allow_0 8, clear 2, allow_1 8, allow_2 8, allow_3 8, then allow_0 (wrap); jam_mode=0 throughout.
REQ-026 jam_sensor_2 held high from reset -> allow_2 16 (jam_mode=1), clear 2, allow_2 16, clear 2, allow_3 8 (jam_mode=0, forced), clear 2, allow_2 16.
REQ-027 Road 1 green, jam_sensor_1 and jam_sensor_3 high during the last CLEAR cycle -> next grant road 3 for 16 cycles (search order 2,3).
REQ-028 jam_sensor_0 pulsed for 3 cycles mid-green and low during the last CLEAR cycle -> ignored; normal next road granted for 8 cycles.
REQ-029 rst asserted at cycle 5 of an allow_1 green -> next cycle allow_1=0, clear=1, current_road=3, jam_mode=0; after release allow_0 follows 2 clear cycles.
REQ-030 Random sensor stimulus, 10k cycles -> REQ-019 one-hot/exclusivity holds every cycle; every green length equals 8 or 16 matching jam_mode.
